// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte FIFO plus send scheduler feeding the UART transmit control stage.
//   Bytes written on Wr_En are queued. Each byte is presented on
//   Tx_En_Sig/Tx_Data and held until the transmit stage returns its
//   one-cycle Tx_Done_Sig pulse. After that, a GAP_CYC-cycle idle gap is
//   inserted before the next byte is presented.
//
// Ports
//   CLOCK_50M    in   system clock, rising edge
//   RST          in   synchronous active-high reset
//   Wr_En        in   write strobe, one byte per high cycle
//   Wr_Data      in   [7:0] byte to enqueue
//   Full         out  FIFO holds 2**ADDR_W bytes
//   Empty        out  FIFO holds 0 bytes
//   Level        out  [ADDR_W:0] FIFO occupancy
//   Busy         out  scheduler not idle
//   Tx_En_Sig    out  enable to transmit stage
//   Tx_Data      out  [7:0] byte to transmit stage, stable while Tx_En_Sig high
//   Tx_Done_Sig  in   end-of-byte pulse from transmit stage
//
// Optional build macro UART_TX_FEEDER_OVF_EN adds these ports:
//   Ovf          out  sticky flag, set by a write attempted while Full
//   Ovf_Clr      in   clears Ovf. Clear wins over a simultaneous set.

module uart_tx_feeder #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned GAP_CYC = 8
) (
    input  logic              CLOCK_50M,
    input  logic              RST,
    input  logic              Wr_En,
    input  logic [7:0]        Wr_Data,
    output logic              Full,
    output logic              Empty,
    output logic [ADDR_W:0]   Level,
    output logic              Busy,
    output logic              Tx_En_Sig,
    output logic [7:0]        Tx_Data,
`ifdef UART_TX_FEEDER_OVF_EN
    output logic              Ovf,
    input  logic              Ovf_Clr,
`endif
    input  logic              Tx_Done_Sig
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_W:0]     level_q;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                tx_en_d;
    logic [7:0]          tx_data_d;
    logic                wr_ok;
    logic                pop;

    assign Full  = (level_q == (ADDR_W+1)'(DEPTH));
    assign Empty = (level_q == '0);
    assign Level = level_q;
    assign Busy  = (state_q != IDLE);

    // Write acceptance uses the pre-edge Full, so a pop in the same cycle
    // does not open room for the incoming byte.
    assign wr_ok = Wr_En && !Full;
    assign pop   = (state_q == SEND) && Tx_Done_Sig;

    // ---------------- FIFO ----------------
    always_ff @(posedge CLOCK_50M) begin
        if (wr_ok && !RST) begin
            mem[wr_ptr] <= Wr_Data;
        end
    end

    always_ff @(posedge CLOCK_50M) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // ---------------- Scheduler FSM: state register ----------------
    always_ff @(posedge CLOCK_50M) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- Scheduler FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!Empty) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (Tx_Done_Sig) begin
                    state_d = (GAP_CYC > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- Scheduler FSM: outputs ----------------
    // Outputs are registered. Next-cycle values are derived from the
    // transition. Because Tx_En_Sig tracks the next state, it stays high
    // through the done cycle and drops on the following cycle.
    always_comb begin
        tx_en_d   = (state_d == SEND);
        tx_data_d = Tx_Data;
        gap_cnt_d = '0;
        if (state_q == IDLE && state_d == SEND) begin
            tx_data_d = mem[rd_ptr];
        end
        if (state_q == GAP && state_d == GAP) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50M) begin
        if (RST) begin
            Tx_En_Sig <= 1'b0;
            Tx_Data   <= 8'h00;
            gap_cnt_q <= '0;
        end else begin
            Tx_En_Sig <= tx_en_d;
            Tx_Data   <= tx_data_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

`ifdef UART_TX_FEEDER_OVF_EN
    // ---------------- Sticky overflow flag ----------------
    always_ff @(posedge CLOCK_50M) begin
        if (RST) begin
            Ovf <= 1'b0;
        end else if (Ovf_Clr) begin
            Ovf <= 1'b0;
        end else if (Wr_En && Full) begin
            Ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
//   Directed bench for uart_tx_feeder with default parameters
//   (ADDR_W = 4, GAP_CYC = 8). Compile with UART_TX_FEEDER_OVF_EN defined
//   to also exercise the overflow flag.

module tb_uart_tx_feeder;

    logic       CLOCK_50M = 1'b0;
    logic       RST = 1'b1;
    logic       Wr_En = 1'b0;
    logic [7:0] Wr_Data = 8'h00;
    logic       Full, Empty, Busy, Tx_En_Sig;
    logic [4:0] Level;
    logic [7:0] Tx_Data;
    logic       Tx_Done_Sig = 1'b0;
`ifdef UART_TX_FEEDER_OVF_EN
    logic       Ovf;
    logic       Ovf_Clr = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    uart_tx_feeder #(.ADDR_W(4), .GAP_CYC(8)) dut (
        .CLOCK_50M   (CLOCK_50M),
        .RST         (RST),
        .Wr_En       (Wr_En),
        .Wr_Data     (Wr_Data),
        .Full        (Full),
        .Empty       (Empty),
        .Level       (Level),
        .Busy        (Busy),
        .Tx_En_Sig   (Tx_En_Sig),
        .Tx_Data     (Tx_Data),
`ifdef UART_TX_FEEDER_OVF_EN
        .Ovf         (Ovf),
        .Ovf_Clr     (Ovf_Clr),
`endif
        .Tx_Done_Sig (Tx_Done_Sig)
    );

    always #10 CLOCK_50M = ~CLOCK_50M;

    task automatic step();
        @(posedge CLOCK_50M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Steps until Tx_En_Sig is high or the budget runs out.
    task automatic wait_en(input int max, output int n);
        n = 0;
        while (Tx_En_Sig !== 1'b1 && n < max) begin
            step();
            n++;
        end
        chk("wait_en_timeout", {31'd0, Tx_En_Sig}, 32'd1);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (Busy !== 1'b0 && n < max) begin
            step();
            n++;
        end
        chk("wait_idle_timeout", {31'd0, Busy}, 32'd0);
    endtask

    task automatic send_done();
        Tx_Done_Sig = 1'b1;
        step();
        Tx_Done_Sig = 1'b0;
    endtask

    initial begin
        int  n;
        logic ok;

        // ---------------- Reset ----------------
        step();
        step();
        chk("rst_level", Level, 0);
        chk("rst_empty", Empty, 1);
        chk("rst_full",  Full,  0);
        chk("rst_busy",  Busy,  0);
        chk("rst_txen",  Tx_En_Sig, 0);
        chk("rst_txdata", Tx_Data, 8'h00);
`ifdef UART_TX_FEEDER_OVF_EN
        chk("rst_ovf", Ovf, 0);
`endif
        RST = 1'b0;
        step();

        // ---------------- Single byte A5 ----------------
        Wr_En = 1'b1; Wr_Data = 8'hA5;
        step();
        Wr_En = 1'b0;
        chk("a5_empty_next", Empty, 0);
        chk("a5_level", Level, 1);
        chk("a5_txen_early", Tx_En_Sig, 0);
        step();
        chk("a5_txen_rise", Tx_En_Sig, 1);
        chk("a5_txdata", Tx_Data, 8'hA5);
        chk("a5_busy", Busy, 1);
        ok = 1'b1;
        repeat (119) begin
            step();
            if (Tx_En_Sig !== 1'b1 || Tx_Data !== 8'hA5) ok = 1'b0;
        end
        chk("a5_hold", ok, 1);
        send_done();
        chk("a5_txen_fall", Tx_En_Sig, 0);
        chk("a5_level_pop", Level, 0);
        chk("a5_empty_pop", Empty, 1);
        chk("a5_busy_gap", Busy, 1);
        repeat (7) step();
        chk("a5_busy_gap_end", Busy, 1);
        step();
        chk("a5_busy_drop", Busy, 0);

        // ---------------- Burst 01..03 ----------------
        for (int i = 1; i <= 3; i++) begin
            Wr_En = 1'b1; Wr_Data = 8'(i);
            step();
        end
        Wr_En = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            wait_en(20, n);
            if (k > 1) chk("burst_spacing", n + 1, 10);
            chk("burst_data", Tx_Data, k);
            ok = 1'b1;
            repeat (4) begin
                step();
                if (Tx_En_Sig !== 1'b1 || Tx_Data !== 8'(k)) ok = 1'b0;
            end
            chk("burst_hold", ok, 1);
            send_done();
        end
        wait_idle(20);
        chk("burst_empty", Empty, 1);

        // ---------------- 17 writes 00..10, no done ----------------
        Wr_En = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            Wr_Data = 8'(i);
            step();
            if (i == 15) begin
                chk("fill_level16", Level, 16);
                chk("fill_full", Full, 1);
            end
        end
        Wr_En = 1'b0;
        chk("drop_level", Level, 16);
        chk("fill_first_txdata", Tx_Data, 8'h00);
        chk("fill_txen", Tx_En_Sig, 1);
`ifdef UART_TX_FEEDER_OVF_EN
        chk("ovf_set", Ovf, 1);
        step(); step();
        chk("ovf_sticky", Ovf, 1);
        // Clear and set in the same cycle: clear wins
        Wr_En = 1'b1; Wr_Data = 8'h55; Ovf_Clr = 1'b1;
        step();
        Wr_En = 1'b0; Ovf_Clr = 1'b0;
        chk("ovf_clr_wins", Ovf, 0);
        chk("ovf_clr_level", Level, 16);
`endif

        // ---------------- Write EE while full, with done ----------------
        Wr_En = 1'b1; Wr_Data = 8'hEE; Tx_Done_Sig = 1'b1;
        step();
        Wr_En = 1'b0; Tx_Done_Sig = 1'b0;
        chk("ee_level15", Level, 15);
        chk("ee_full", Full, 0);
        chk("ee_txen_fall", Tx_En_Sig, 0);
`ifdef UART_TX_FEEDER_OVF_EN
        chk("ovf_reset_by_ee", Ovf, 1);
        Ovf_Clr = 1'b1;
        step();
        Ovf_Clr = 1'b0;
        chk("ovf_cleared", Ovf, 0);
        step();
        chk("ovf_stays_clear", Ovf, 0);
`endif
        for (int k = 1; k <= 15; k++) begin
            wait_en(20, n);
            chk("drain_data", Tx_Data, k);
            send_done();
        end
        wait_idle(20);
        chk("drain_empty", Empty, 1);
        chk("drain_level", Level, 0);
        ok = 1'b1;
        repeat (20) begin
            step();
            if (Tx_En_Sig !== 1'b0) ok = 1'b0;
        end
        chk("ee_never_sent", ok, 1);

        // ---------------- Reset mid-SEND with Level 5 ----------------
        for (int i = 0; i < 5; i++) begin
            Wr_En = 1'b1; Wr_Data = 8'(8'h11 + i);
            step();
        end
        Wr_En = 1'b0;
        chk("mid_level5", Level, 5);
        chk("mid_txen", Tx_En_Sig, 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("mid_rst_txen", Tx_En_Sig, 0);
        chk("mid_rst_txdata", Tx_Data, 8'h00);
        chk("mid_rst_level", Level, 0);
        chk("mid_rst_empty", Empty, 1);
        chk("mid_rst_busy", Busy, 0);
        Wr_En = 1'b1; Wr_Data = 8'h3C;
        step();
        Wr_En = 1'b0;
        wait_en(10, n);
        chk("after_rst_latency", n, 1);
        chk("after_rst_data", Tx_Data, 8'h3C);
        send_done();
        wait_idle(20);

        // ---------------- Done pulses in IDLE and GAP ----------------
        send_done();
        chk("idle_done_level", Level, 0);
        chk("idle_done_busy", Busy, 0);
        chk("idle_done_empty", Empty, 1);
        Wr_En = 1'b1; Wr_Data = 8'h41;
        step();
        Wr_Data = 8'h42;
        step();
        Wr_En = 1'b0;
        wait_en(10, n);
        chk("gap_first_data", Tx_Data, 8'h41);
        send_done();
        step(); step();
        send_done();
        chk("gap_done_level", Level, 1);
        chk("gap_done_busy", Busy, 1);
        chk("gap_done_txen", Tx_En_Sig, 0);
        wait_en(20, n);
        chk("gap_done_spacing", n + 4, 10);
        chk("gap_second_data", Tx_Data, 8'h42);
        send_done();
        wait_idle(20);
        chk("final_empty", Empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte FIFO plus send scheduler that sits directly upstream of the UART transmit control stage.
- Accepts bytes from the application on a write strobe and buffers them.
- Presents one byte at a time on Tx_En_Sig/Tx_Data, holding it until that stage returns its one-cycle Tx_Done_Sig pulse.
- Inserts a programmable idle gap between back-to-back bytes.

Parameters:
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W entries (16).
- GAP_CYC, 8, CLOCK_50M cycles Tx_En_Sig stays low between consecutive bytes; 0 = no gap state.

Ports:
- CLOCK_50M  input  1  system clock, all logic on rising edge.
- RST  input  1  reset; synchronous, active-high.
- Wr_En  input  1  write strobe, one byte per high cycle.
- Wr_Data  input  8  byte to enqueue.
- Full  output  1  FIFO holds 2**ADDR_W bytes.
- Empty  output  1  FIFO holds 0 bytes.
- Level  output  ADDR_W+1  current FIFO occupancy.
- Busy  output  1  high whenever state is not IDLE.
- Tx_En_Sig  output  1  enable to transmit stage.
- Tx_Data  output  8  byte to transmit stage, stable while Tx_En_Sig high.
- Tx_Done_Sig  input  1  one-cycle pulse from transmit stage at end of byte.

Behaviour:
- Reset, synchronous, applied on any cycle including mid-byte:
  - Rd/Wr pointers = 0, Level = 0, Empty = 1, Full = 0, Busy = 0.
  - Tx_En_Sig = 0, Tx_Data = 8'h00, state = IDLE, gap counter = 0.
  - FIFO contents are not cleared but are unreachable.
- FIFO:
  - Registered Level; Full = (Level == 2**ADDR_W), Empty = (Level == 0).
  - Write accepted iff Wr_En && !Full, evaluated on the pre-edge Full, even if a pop occurs in the same cycle.
  - Pointers wrap modulo 2**ADDR_W.
  - Simultaneous accepted write and pop: Level unchanged, both pointers advance.
  - A byte written into an empty FIFO is visible (Empty = 0) the next cycle.
- State machine (registered outputs):
  - IDLE: Tx_En_Sig = 0. If !Empty, load Tx_Data <= mem[rd_ptr], set Tx_En_Sig <= 1, go to SEND. Tx_Data leaves IDLE no earlier than 1 cycle after Empty deasserts.
  - SEND: Tx_En_Sig = 1, Tx_Data held constant. On Tx_Done_Sig = 1:
    - pop (rd_ptr+1, Level-1);
    - Tx_En_Sig remains 1 during that done cycle so the transmit stage completes its clear step;
    - from the next cycle Tx_En_Sig = 0;
    - go to GAP (GAP_CYC > 0) or IDLE (GAP_CYC = 0).
  - GAP: Tx_En_Sig = 0. Counter counts 0..GAP_CYC-1, then go to IDLE with counter cleared. Writes still accepted.
- Tx_Done_Sig is ignored in IDLE and GAP.
- Minimum spacing between the done pulse and the next Tx_En_Sig rise is GAP_CYC+2 cycles.
- Tx_Data never changes while Tx_En_Sig = 1.
- Busy = (state != IDLE).

Optional Feature:
- Macro UART_TX_FEEDER_OVF_EN.
- When defined:
  - Adds output port Ovf (1 bit), reset 0.
  - Ovf goes high the cycle after Wr_En while Full and stays high (sticky).
  - Adds input Ovf_Clr (1 bit); Ovf_Clr = 1 clears Ovf next cycle.
  - Clear wins over a simultaneous set.
- When undefined: neither port exists and dropped writes are silent.

Test Plan:
- Reset, write 8'hA5 once, model Tx_Done_Sig 120 cycles after Tx_En_Sig rises:
  - Tx_En_Sig rises 2 cycles after the write, with Tx_Data = 8'hA5.
  - Falls the cycle after the done pulse.
  - Level returns to 0, Empty = 1, Busy drops after the GAP_CYC = 8 gap.
- Burst-write 8'h01..8'h03 on consecutive cycles:
  - Bytes emitted in order 01, 02, 03.
  - Each Tx_En_Sig rise is exactly 10 cycles after the previous done pulse.
  - Tx_Data stable throughout each high window.
- Write 17 bytes 8'h00..8'h10 back-to-back with no done pulses:
  - Full = 1 after the 16th write, Level = 16.
  - Byte 8'h10 dropped; the first 16 bytes are emitted in order afterward.
  - With UART_TX_FEEDER_OVF_EN: Ovf = 1 and stays 1 until Ovf_Clr.
- With FIFO full, assert Wr_En (8'hEE) in the same cycle as Tx_Done_Sig:
  - Write rejected, Level goes 16 -> 15.
  - 8'hEE is never transmitted.
- Assert RST for 1 cycle mid-SEND with Level = 5:
  - Next cycle Tx_En_Sig = 0, Tx_Data = 8'h00, Level = 0, Empty = 1, state IDLE.
  - A subsequent write of 8'h3C is the next byte sent.
- Pulse Tx_Done_Sig while in IDLE and while in GAP:
  - No pop, Level unchanged, no state change.
